// File: rtl/bitlink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bitlink_pkg
// Description : Shared types and constants for the bit-clock-recovery link.
// Revision    : 1.0 - initial release
// ============================================================================
package bitlink_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2
    } state_t;

    localparam int unsigned MIN_BIT_PERIOD     = 2;
    // Matches the receiver's post-reset bit interval.
    localparam logic [15:0] DEFAULT_BIT_PERIOD = 16'd801;

endpackage
`default_nettype wire

// File: rtl/bit_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : bit_tick_gen
// Description : Per-bit tick counter; latches a clamped period at frame start
//               and flags the last and second-to-last cycle of every bit.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_tick_gen
    import bitlink_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk_200M,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_run,
    input  logic [PERIOD_W-1:0] i_bit_period,
    output logic                o_boundary,
    output logic                o_pre_boundary
);

    localparam logic [PERIOD_W-1:0] c_ONE        = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] c_TWO        = PERIOD_W'(2);
    localparam logic [PERIOD_W-1:0] c_MIN_PERIOD = PERIOD_W'(MIN_BIT_PERIOD);
    localparam logic [PERIOD_W-1:0] c_RST_PERIOD = PERIOD_W'(DEFAULT_BIT_PERIOD);

    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_count;
    logic [PERIOD_W-1:0] w_period_clamped;

    // A period below 2 would leave no room for the ready cycle before a boundary.
    assign w_period_clamped = (i_bit_period < c_MIN_PERIOD) ? c_MIN_PERIOD : i_bit_period;
    assign o_boundary       = i_run && (r_count == (r_period - c_ONE));
    assign o_pre_boundary   = i_run && (r_count == (r_period - c_TWO));

    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            r_period <= c_RST_PERIOD;
            r_count  <= '0;
        end else if (i_start) begin
            r_period <= w_period_clamped;
            r_count  <= '0;
        end else if (o_boundary || !i_run) begin
            r_count  <= '0;
        end else begin
            r_count  <= r_count + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bit_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : bit_stream_tx
// Description : NRZ serial transmitter; alternating preamble then bytes
//               MSB-first at a programmable bit period.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_stream_tx
    import bitlink_pkg::*;
#(
    parameter int PERIOD_W      = 16,
    parameter int PREAMBLE_BITS = 32,
    parameter bit IDLE_LEVEL    = 1'b0
) (
    input  logic                clk_200M,
    input  logic                rst_n,
    input  logic [PERIOD_W-1:0] bit_period,
    input  logic [7:0]          data_in,
    input  logic                data_valid,
    output logic                data_ready,
    output logic                signal,
    output logic                tx_active,
    output logic                bit_strobe
);

    localparam int                 c_PRE_W    = $clog2(PREAMBLE_BITS);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(PREAMBLE_BITS - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_ONE  = c_PRE_W'(1);

    state_t             r_state;
    logic               r_signal;
    logic               r_tx_active;
    logic               r_data_ready;
    logic               r_bit_strobe;
    logic [c_PRE_W-1:0] r_pre_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;

    logic w_start;
    logic w_run;
    logic w_boundary;
    logic w_pre_boundary;

    assign w_start = (r_state == IDLE) && data_valid;
    assign w_run   = (r_state != IDLE);

    bit_tick_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tick_gen (
        .clk_200M       (clk_200M),
        .rst_n          (rst_n),
        .i_start        (w_start),
        .i_run          (w_run),
        .i_bit_period   (bit_period),
        .o_boundary     (w_boundary),
        .o_pre_boundary (w_pre_boundary)
    );

    always_ff @(posedge clk_200M or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_signal     <= IDLE_LEVEL;
            r_tx_active  <= 1'b0;
            r_data_ready <= 1'b0;
            r_bit_strobe <= 1'b0;
            r_pre_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
        end else begin
            r_bit_strobe <= 1'b0;
            r_data_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_signal    <= IDLE_LEVEL;
                    r_tx_active <= 1'b0;
                    if (data_valid) begin
                        r_state      <= PREAMBLE;
                        r_signal     <= 1'b1;
                        r_tx_active  <= 1'b1;
                        r_bit_strobe <= 1'b1;
                        r_pre_cnt    <= '0;
                    end
                end
                PREAMBLE: begin
                    // Ready is raised one cycle early so it is registered on the boundary cycle.
                    r_data_ready <= w_pre_boundary && (r_pre_cnt == c_PRE_LAST);
                    if (w_boundary && (r_pre_cnt != c_PRE_LAST)) begin
                        r_pre_cnt    <= r_pre_cnt + c_PRE_ONE;
                        r_signal     <= ~r_signal;
                        r_bit_strobe <= 1'b1;
                    end
                end
                DATA: begin
                    r_data_ready <= w_pre_boundary && (r_bit_idx == 3'd7);
                    if (w_boundary && (r_bit_idx != 3'd7)) begin
                        r_bit_idx    <= r_bit_idx + 3'd1;
                        r_shift      <= {r_shift[6:0], 1'b0};
                        r_signal     <= r_shift[6];
                        r_bit_strobe <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Byte load point: end of preamble or end of bit 7; no byte means underrun.
            if (w_boundary && r_data_ready) begin
                if (data_valid) begin
                    r_state      <= DATA;
                    r_shift      <= data_in;
                    r_signal     <= data_in[7];
                    r_bit_idx    <= '0;
                    r_bit_strobe <= 1'b1;
                end else begin
                    r_state      <= IDLE;
                    r_signal     <= IDLE_LEVEL;
                    r_tx_active  <= 1'b0;
                end
            end
        end
    end

    assign data_ready = r_data_ready;
    assign signal     = r_signal;
    assign tx_active  = r_tx_active;
    assign bit_strobe = r_bit_strobe;

endmodule
`default_nettype wire

// File: tb/tb_bit_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_stream_tx
// Description : Directed self-checking bench for bit_stream_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_stream_tx;

    localparam int PERIOD_W = 16;
    localparam int PRE_BITS = 32;
    localparam bit IDLE_LVL = 1'b0;

    logic                clk_200M = 1'b0;
    logic                rst_n;
    logic [PERIOD_W-1:0] bit_period;
    logic [7:0]          data_in;
    logic                data_valid;
    logic                data_ready;
    logic                signal;
    logic                tx_active;
    logic                bit_strobe;

    bit_stream_tx #(
        .PERIOD_W      (PERIOD_W),
        .PREAMBLE_BITS (PRE_BITS),
        .IDLE_LEVEL    (IDLE_LVL)
    ) dut (
        .clk_200M   (clk_200M),
        .rst_n      (rst_n),
        .bit_period (bit_period),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .signal     (signal),
        .tx_active  (tx_active),
        .bit_strobe (bit_strobe)
    );

    always #5 clk_200M = ~clk_200M;

    int   n_checks = 0;
    int   n_errors = 0;
    logic s_sig, s_tx, s_rdy, s_stb;
    logic q_sig[$];
    logic q_stb[$];
    int   hs_cnt, rdy_cnt, idle_stb, idle_bad;
    logic [7:0] tx_bytes [0:3];
    int   n_bytes, byte_idx;
    logic gate;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        data_valid = gate && (byte_idx < n_bytes);
        data_in    = (byte_idx < n_bytes) ? tx_bytes[byte_idx] : 8'h00;
    endtask

    // One clock: sample at the falling edge, then drive just after the rising edge.
    task automatic tick();
        logic hs;
        @(negedge clk_200M);
        s_sig = signal;
        s_tx  = tx_active;
        s_rdy = data_ready;
        s_stb = bit_strobe;
        hs    = data_valid && data_ready;
        if (s_tx) begin
            q_sig.push_back(s_sig);
            q_stb.push_back(s_stb);
        end else begin
            if (s_stb) idle_stb++;
            if (s_sig !== IDLE_LVL) idle_bad++;
        end
        if (hs) hs_cnt++;
        if (s_rdy) rdy_cnt++;
        @(posedge clk_200M);
        #1;
        if (hs) byte_idx++;
        drive();
    endtask

    task automatic start_frame(input logic [15:0] per, input int nb,
                               input logic [7:0] b0, input logic [7:0] b1);
        bit_period  = per;
        tx_bytes[0] = b0;
        tx_bytes[1] = b1;
        n_bytes     = nb;
        byte_idx    = 0;
        gate        = 1'b1;
        q_sig.delete();
        q_stb.delete();
        hs_cnt = 0; rdy_cnt = 0; idle_stb = 0; idle_bad = 0;
        drive();
        tick();
        check("lat_idle_tx", 32'(s_tx), 32'd0);
        tick();
        check("lat_sig", 32'(s_sig), 32'd1);
        check("lat_tx", 32'(s_tx), 32'd1);
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n;
        n = 0;
        while (hs_cnt < target && n < budget) begin
            tick();
            n++;
        end
        check("hs_timeout", 32'(hs_cnt >= target), 32'd1);
    endtask

    task automatic wait_end(input int budget);
        int n;
        n = 0;
        while (s_tx && n < budget) begin
            tick();
            n++;
        end
        check("end_timeout_tx", 32'(s_tx), 32'd0);
        check("end_sig_idle", 32'(s_sig), 32'(IDLE_LVL));
    endtask

    task automatic check_frame(input logic [15:0] per, input int nb,
                               input logic [7:0] b0, input logic [7:0] b1);
        int          p;
        int          nbits;
        logic [15:0] bytes2;
        logic [31:0] ws, wt, es;
        logic        eb;
        p      = (per < 16'd2) ? 2 : int'(per);
        nbits  = PRE_BITS + 8 * nb;
        bytes2 = {b0, b1};
        check($sformatf("len_p%0d", per), 32'(q_sig.size()), 32'(nbits * p));
        check("handshakes", 32'(hs_cnt), 32'(nb));
        check("ready_cycles", 32'(rdy_cnt), 32'(nb + 1));
        check("idle_strobe", 32'(idle_stb), 32'd0);
        check("idle_level", 32'(idle_bad), 32'd0);
        for (int b = 0; b < nbits; b++) begin
            ws = '0;
            wt = '0;
            for (int j = 0; j < p; j++) begin
                if (b * p + j < q_sig.size()) begin
                    ws[j] = q_sig[b * p + j];
                    wt[j] = q_stb[b * p + j];
                end
            end
            if (b < PRE_BITS) eb = ((b % 2) == 0);
            else              eb = bytes2[15 - (b - PRE_BITS)];
            es = eb ? ((32'd1 << p) - 32'd1) : 32'd0;
            check($sformatf("sig_p%0d_bit%0d", per, b), ws, es);
            check($sformatf("stb_p%0d_bit%0d", per, b), wt, 32'd1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        bit_period = 16'd4;
        data_in    = 8'h00;
        data_valid = 1'b0;
        gate       = 1'b0;
        n_bytes    = 0;
        byte_idx   = 0;
        hs_cnt = 0; rdy_cnt = 0; idle_stb = 0; idle_bad = 0;
        s_tx = 1'b0; s_sig = 1'b0; s_rdy = 1'b0; s_stb = 1'b0;

        repeat (3) tick();
        check("rst_signal", 32'(s_sig), 32'(IDLE_LVL));
        check("rst_tx_active", 32'(s_tx), 32'd0);
        check("rst_data_ready", 32'(s_rdy), 32'd0);
        check("rst_bit_strobe", 32'(s_stb), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_after_rst_tx", 32'(s_tx), 32'd0);

        // Reset mid-frame: abort during DATA while the line is high.
        start_frame(16'd4, 1, 8'hA5, 8'h00);
        wait_hs(1, 1000);
        repeat (2) tick();
        check("pre_abort_tx", 32'(tx_active), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_signal", 32'(signal), 32'(IDLE_LVL));
        check("abort_tx_active", 32'(tx_active), 32'd0);
        check("abort_data_ready", 32'(data_ready), 32'd0);
        n_bytes = 0;
        drive();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        start_frame(16'd4, 1, 8'h81, 8'h00);
        wait_end(2000);
        check_frame(16'd4, 1, 8'h81, 8'h00);

        // Single byte.
        start_frame(16'd4, 1, 8'hA5, 8'h00);
        wait_end(2000);
        check_frame(16'd4, 1, 8'hA5, 8'h00);

        // Back-to-back bytes with valid held.
        start_frame(16'd10, 2, 8'h00, 8'hFF);
        wait_end(2000);
        check_frame(16'd10, 2, 8'h00, 8'hFF);

        // Period clamp.
        start_frame(16'd0, 1, 8'h3C, 8'h00);
        wait_end(2000);
        check_frame(16'd0, 1, 8'h3C, 8'h00);
        start_frame(16'd1, 1, 8'hC3, 8'h00);
        wait_end(2000);
        check_frame(16'd1, 1, 8'hC3, 8'h00);

        // Mid-frame period change is ignored; the next frame picks it up.
        start_frame(16'd6, 1, 8'h96, 8'h00);
        wait_hs(1, 1000);
        bit_period = 16'd3;
        wait_end(2000);
        check_frame(16'd6, 1, 8'h96, 8'h00);
        start_frame(16'd3, 1, 8'h69, 8'h00);
        wait_end(2000);
        check_frame(16'd3, 1, 8'h69, 8'h00);

        // Underrun: second byte withdrawn one cycle before its ready cycle.
        start_frame(16'd4, 2, 8'h5A, 8'hC3);
        wait_hs(1, 1000);
        repeat (8 * 4 - 2) tick();
        gate = 1'b0;
        drive();
        wait_end(2000);
        check_frame(16'd4, 1, 8'h5A, 8'h00);
        n_bytes = 0;
        gate    = 1'b1;
        drive();
        repeat (3) tick();
        check("post_underrun_idle", 32'(s_tx), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
